// File: rtl/shift8_seq.sv
// rtl/shift8_seq.sv - sequential 8-bit shifter: shifts 0..7 positions in steps of up to 3 per clock
module shift8_seq #(
    parameter int WIDTH    = 8,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [2:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] STEP_MAX_V = 3'(STEP_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       remain_q, remain_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;

    logic [1:0]       step;
    logic [2:0]       remain_next;
    logic [WIDTH-1:0] shifted;

    // One combinational step of 0..3 positions; ROR takes the low half of a doubled word.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] w,
        input logic [1:0]       o,
        input logic [1:0]       k
    );
        logic [2*WIDTH-1:0] rot;
        rot = {w, w} >> k;
        case (o)
            2'b00:   return w << k;
            2'b01:   return w >> k;
            2'b10:   return $unsigned($signed(w) >>> k);
            default: return rot[WIDTH-1:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        remain_d    = remain_q;
        op_d        = op_q;
        d_out_d     = d_out_q;
        step        = (remain_q >= STEP_MAX_V) ? STEP_MAX_V[1:0] : remain_q[1:0];
        remain_next = remain_q - {1'b0, step};
        shifted     = step_shift(work_q, op_q, step);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    work_d   = d_in;
                    remain_d = shamt;
                    op_d     = op;
                    if (shamt == 3'd0) begin
                        // Zero shift: the operand is the result, published on this edge.
                        state_d = S_DONE;
                        d_out_d = d_in;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d   = shifted;
                remain_d = remain_next;
                if (remain_next == 3'd0) begin
                    state_d = S_DONE;
                    d_out_d = shifted;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            remain_q <= '0;
            op_q     <= '0;
            d_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            op_q     <= op_d;
            d_out_q  <= d_out_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign d_out = d_out_q;

endmodule

// File: tb/tb_shift8_seq.sv
// tb/tb_shift8_seq.sv - self-checking bench for shift8_seq against a whole-amount shift model
module tb_shift8_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;

    int checks = 0;
    int errors = 0;

    shift8_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .d_in    (d_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .d_out   (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: apply the full shift amount at once with plain arithmetic.
    function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [1:0] o, input int s);
        int          v;
        logic [15:0] dbl;
        case (o)
            2'b00: v = (int'(d) << s) & 255;
            2'b01: v = int'(d) >> s;
            2'b10: begin
                v = d[7] ? int'(d) - 256 : int'(d);
                v = (v >>> s) & 255;
            end
            default: begin
                dbl = {d, d};
                dbl = dbl >> s;
                v   = int'(dbl[7:0]);
            end
        endcase
        return v[7:0];
    endfunction

    function automatic int model_latency(input int s);
        return (s + 2) / 3 + 1;
    endfunction

    // Called #1 after a rising edge in IDLE or DONE; returns #1 after the edge that raised done.
    task automatic run_op(input logic [7:0] d, input logic [1:0] o, input logic [2:0] s,
                          output logic [7:0] res, output int lat, output int busy_cycles);
        start = 1'b1; d_in = d; op = o; shamt = s;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 16) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy === 1'b1) busy_cycles++;
        res = d_out;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; op = 2'b00; d_in = 8'h00; shamt = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b d_out=%h, required 0 0 00", busy, done, d_out);
        end
        reset_n = 1'b1;
        idle_cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_lsl();
        logic [7:0] res; int lat, bc;
        run_op(8'hB5, 2'b00, 3'd7, res, lat, bc);
        checks++;
        if (res !== 8'h80) begin errors++; $display("FAIL lsl_result: d_out=%h, required 80", res); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL lsl_latency: %0d cycles, required 4", lat); end
        checks++;
        if (bc != 4) begin errors++; $display("FAIL lsl_busy: %0d cycles, required 4", bc); end
        idle_cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h80) begin
            errors++;
            $display("FAIL lsl_after: busy=%b done=%b d_out=%h, required 0 0 80", busy, done, d_out);
        end
    endtask

    task automatic test_lsr_asr();
        logic [7:0] res; int lat, bc;
        run_op(8'hB5, 2'b01, 3'd4, res, lat, bc);
        checks++;
        if (res !== 8'h0B || lat != 3) begin
            errors++;
            $display("FAIL lsr: d_out=%h lat=%0d, required 0b lat 3", res, lat);
        end
        idle_cycle();
        run_op(8'hB5, 2'b10, 3'd5, res, lat, bc);
        checks++;
        if (res !== 8'hFD || lat != 3) begin
            errors++;
            $display("FAIL asr: d_out=%h lat=%0d, required fd lat 3", res, lat);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] res; int lat, bc;
        run_op(8'hB5, 2'b11, 3'd3, res, lat, bc);
        checks++;
        if (res !== 8'hB6 || lat != 2) begin
            errors++;
            $display("FAIL ror: d_out=%h lat=%0d, required b6 lat 2", res, lat);
        end
        // Still in the DONE cycle: the next request is accepted here.
        run_op(8'h3C, 2'b00, 3'd0, res, lat, bc);
        checks++;
        if (res !== 8'h3C || lat != 1) begin
            errors++;
            $display("FAIL back_to_back: d_out=%h lat=%0d, required 3c lat 1", res, lat);
        end
        idle_cycle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_ignored_start();
        int done_count = 0;
        int lat = 0;
        start = 1'b1; d_in = 8'hF0; op = 2'b01; shamt = 3'd6;
        @(posedge clk); #1;
        lat = 1;
        start = 1'b1; d_in = 8'h01; op = 2'b00; shamt = 3'd0;
        @(posedge clk); #1;
        lat++;
        start = 1'b0; d_in = 8'hAA; op = 2'b11; shamt = 3'd7;
        while (done !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (d_out !== 8'h03 || lat != 3) begin
            errors++;
            $display("FAIL ignored_start: d_out=%h lat=%0d, required 03 lat 3", d_out, lat);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_count++;
        end
        checks++;
        if (done_count != 0 || d_out !== 8'h03) begin
            errors++;
            $display("FAIL ignored_extra_done: %0d extra dones d_out=%h, required 0 and 03", done_count, d_out);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_count = 0;
        start = 1'b1; d_in = 8'hB5; op = 2'b00; shamt = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b d_out=%h, required 0 0 00", busy, done, d_out);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_count++;
        end
        checks++;
        if (done_count != 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d busy/done cycles after release, required 0", done_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, res, exp_res;
        logic [1:0] o;
        logic [2:0] s;
        int lat, bc;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            o = 2'($urandom);
            s = 3'($urandom_range(0, 7));
            exp_res = model_shift(d, o, int'(s));
            run_op(d, o, s, res, lat, bc);
            checks++;
            if (res !== exp_res || lat != model_latency(int'(s)) || bc != lat) begin
                errors++;
                $display("FAIL random_%0d: d=%h op=%0d sh=%0d got %h lat %0d busy %0d, required %h lat %0d",
                         n, d, o, s, res, lat, bc, exp_res, model_latency(int'(s)));
            end
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_lsr_asr();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
